// File: rtl/adder_4bit_pkg.sv
// ---------------------------------------------------------------------------
// adder_4bit_pkg
// Shared constants for the ripple-carry adder slice.
//   ADDER_WIDTH : default operand width in bits
// ---------------------------------------------------------------------------
package adder_4bit_pkg;

    localparam int ADDER_WIDTH = 4;

endpackage : adder_4bit_pkg

// File: rtl/adder_4bit_if.sv
// ---------------------------------------------------------------------------
// adder_4bit_if
// Operand/result bundle for adder_4bit.
//   A, B, Ci       : operands and carry-in (driven by the master)
//   S, Co, V       : combinational sum, carry-out, signed overflow
//   S_q, Co_q, V_q : the same results registered one clock later
// Modports:
//   master : drives operands, observes results
//   slave  : the adder itself
// ---------------------------------------------------------------------------
interface adder_4bit_if
    import adder_4bit_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) ();

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Ci;
    logic [WIDTH-1:0] S;
    logic             Co;
    logic             V;
    logic [WIDTH-1:0] S_q;
    logic             Co_q;
    logic             V_q;

    modport master (
        output A, B, Ci,
        input  S, Co, V, S_q, Co_q, V_q
    );

    modport slave (
        input  A, B, Ci,
        output S, Co, V, S_q, Co_q, V_q
    );

endinterface : adder_4bit_if

// File: rtl/adder_4bit_full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// Single-bit full-adder cell used to build the ripple chain.
//   a, b, cin : input bits
//   s         : sum bit
//   cout      : carry out
// Plain gate expressions, so X/Z on any input propagates without masking.
// ---------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/adder_4bit.sv
// ---------------------------------------------------------------------------
// adder_4bit
// WIDTH-bit ripple-carry adder with combinational and registered results.
//   clk : rising-edge clock for the registered results
//   rst : synchronous active-high reset, clears S_q/Co_q/V_q only
//   bus : adder_4bit_if.slave
//           in  : A, B, Ci
//           out : S, Co, V (combinational), S_q, Co_q, V_q (registered)
// ---------------------------------------------------------------------------
module adder_4bit
    import adder_4bit_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    adder_4bit_if.slave  bus
);

    // carry[i] is the carry into bit i; carry[WIDTH] is the final carry-out
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;
    logic             ovf;

    assign carry[0] = bus.Ci;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder u_fa (
            .a    (bus.A[i]),
            .b    (bus.B[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

    // Signed overflow: carry into the MSB differs from carry out of it
    assign ovf = carry[WIDTH] ^ carry[WIDTH-1];

    assign bus.S  = sum;
    assign bus.Co = carry[WIDTH];
    assign bus.V  = ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.S_q  <= '0;
            bus.Co_q <= 1'b0;
            bus.V_q  <= 1'b0;
        end else begin
            bus.S_q  <= sum;
            bus.Co_q <= carry[WIDTH];
            bus.V_q  <= ovf;
        end
    end

endmodule : adder_4bit

// File: tb/tb_adder_4bit.sv
// ---------------------------------------------------------------------------
// tb_adder_4bit
// Directed self-checking bench for adder_4bit. Combinational results are
// checked against a reference sum right after inputs are driven; registered
// results are pushed to a queue at drive time and popped after the next
// rising edge.
// ---------------------------------------------------------------------------
module tb_adder_4bit;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         v;
    } res_t;

    logic clk;
    logic rst;
    res_t exp_q[$];
    int   n_total;
    int   n_pass;

    adder_4bit_if #(.WIDTH(W)) bus ();

    adder_4bit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic ci);
        res_t       r;
        logic [W:0] full;
        full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        r.s   = full[W-1:0];
        r.co  = full[W];
        r.v   = (a[W-1] == b[W-1]) && (r.s[W-1] != a[W-1]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] expv);
        n_total++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // One directed step: drive at negedge, check combinational outputs,
    // queue the registered expectation, then check registers after posedge.
    task automatic step(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic r);
        res_t e;
        res_t got;
        @(negedge clk);
        bus.A  = a;
        bus.B  = b;
        bus.Ci = ci;
        rst    = r;
        #1;
        e = ref_add(a, b, ci);
        check({tag, ".S"},  bus.S,  e.s);
        check({tag, ".Co"}, {{(W-1){1'b0}}, bus.Co}, {{(W-1){1'b0}}, e.co});
        check({tag, ".V"},  {{(W-1){1'b0}}, bus.V},  {{(W-1){1'b0}}, e.v});
        exp_q.push_back(r ? res_t'('0) : e);
        @(posedge clk);
        #1;
        n_total++;
        assert (exp_q.size() != 0) begin
            n_pass++;
            got = exp_q.pop_front();
            check({tag, ".S_q"},  bus.S_q, got.s);
            check({tag, ".Co_q"}, {{(W-1){1'b0}}, bus.Co_q}, {{(W-1){1'b0}}, got.co});
            check({tag, ".V_q"},  {{(W-1){1'b0}}, bus.V_q},  {{(W-1){1'b0}}, got.v});
        end else begin
            $error("FAIL %s.queue observed=empty expected=entry", tag);
        end
    endtask

    initial begin
        logic ci;
        n_total = 0;
        n_pass  = 0;
        rst     = 1'b1;
        bus.A   = '0;
        bus.B   = '0;
        bus.Ci  = 1'b0;

        // Reset state with non-zero operands: registers must read zero
        step("reset",  4'd9,  4'd9,  1'b1, 1'b1);

        step("t5_0_1",   4'd5,  4'd0,  1'b1, 1'b0);
        step("t5_15_1",  4'd5,  4'd15, 1'b1, 1'b0);
        step("wrap",     4'd15, 4'd0,  1'b1, 1'b0);
        step("allones",  4'd15, 4'd15, 1'b1, 1'b0);
        step("ovf_pos",  4'd7,  4'd1,  1'b0, 1'b0);
        step("ovf_neg",  4'd8,  4'd8,  1'b0, 1'b0);

        // Explicit constants for the boundary cases, independent of the model
        @(negedge clk);
        bus.A = 4'd15; bus.B = 4'd0; bus.Ci = 1'b1;
        #1;
        check("wrap_const.S",  bus.S, 4'd0);
        check("wrap_const.Co", {3'b0, bus.Co}, 4'd1);
        bus.A = 4'd8; bus.B = 4'd8; bus.Ci = 1'b0;
        #1;
        check("ovf_const.V",  {3'b0, bus.V}, 4'd1);
        check("ovf_const.S",  bus.S, 4'd0);

        // Sweep B with Ci toggling every clock
        ci = 1'b0;
        for (int b = 0; b < 16; b++) begin
            step($sformatf("sweep_b%0d", b), 4'd5, 4'(b), ci, 1'b0);
            ci = ~ci;
        end

        // Mid-stream reset: combinational path keeps tracking, registers clear
        step("pre_rst",  4'd3, 4'd4, 1'b0, 1'b0);
        step("mid_rst",  4'd9, 4'd9, 1'b1, 1'b1);
        check("mid_rst_const.S", bus.S, 4'd3);
        check("mid_rst_const.Co", {3'b0, bus.Co}, 4'd1);
        step("post_rst", 4'd9, 4'd9, 1'b1, 1'b0);
        check("post_rst_const.S_q", bus.S_q, 4'd3);
        check("post_rst_const.Co_q", {3'b0, bus.Co_q}, 4'd1);

        // Unknown carry-in must reach the sum without masking
        @(negedge clk);
        bus.A = 4'd0; bus.B = 4'd0; bus.Ci = 1'bx;
        #1;
        check("xprop.S",  bus.S, 4'b000x);
        check("xprop.Co", {3'b0, bus.Co}, 4'd0);
        bus.A = 4'bxxxx; bus.B = 4'd0; bus.Ci = 1'b0;
        #1;
        check("xprop_a.S", bus.S, 4'bxxxx);

        step("final", 4'd1, 4'd2, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_adder_4bit

// File: doc/adder_4bit.md
ADDER_4BIT -- requirements
Module: adder_4bit

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have parameter WIDTH, default 4, setting the operand width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock for the registered outputs.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port A, input, WIDTH bits: unsigned/two's-complement operand A.
REQ-006 The block SHALL have port B, input, WIDTH bits: operand B.
REQ-007 The block SHALL have port Ci, input, 1 bit: carry-in.
REQ-008 The block SHALL have port S, output, WIDTH bits: combinational sum.
REQ-009 The block SHALL have port Co, output, 1 bit: combinational carry-out.
REQ-010 The block SHALL have port V, output, 1 bit: combinational signed overflow.
REQ-011 The block SHALL have port S_q, output, WIDTH bits: registered S.
REQ-012 The block SHALL have port Co_q, output, 1 bit: registered Co.
REQ-013 The block SHALL have port V_q, output, 1 bit: registered V.

Function
REQ-014 The block SHALL form {Co,S} = A + B + Ci as a (WIDTH+1)-bit unsigned result, with no truncation of the carry.
REQ-015 S, Co and V SHALL be purely combinational, with zero-cycle latency, and SHALL settle within the same simulation time step as an input change.
REQ-016 The adder SHALL be a ripple-carry chain of WIDTH full-adder cells; bit 0 carry-in is Ci and bit WIDTH-1 carry-out is Co.
REQ-017 Each cell SHALL compute s = a^b^cin and cout = (a&b)|(a&cin)|(b&cin).
REQ-018 V SHALL equal the XOR of the carry into the MSB and the carry out of the MSB.
REQ-019 At the boundary 2^WIDTH-1 + 0 + 1 the sum SHALL wrap: S=0, Co=1.
REQ-020 The all-ones case (all-ones + all-ones + 1) SHALL give S=all-ones and Co=1.
REQ-021 On each rising clk edge with rst=0, S_q, Co_q and V_q SHALL load S, Co and V, giving one-cycle latency.
REQ-022 X/Z on any input SHALL propagate to the combinational outputs; no masking is applied.

Reset
REQ-023 When rst=1 at a rising clk edge, S_q, Co_q and V_q SHALL become 0.
REQ-024 Reset SHALL NOT affect S, Co or V; they continue to track the inputs during reset.
REQ-025 If rst is asserted mid-stream, the registered outputs SHALL be 0 on the following cycle and resume loading the sum on the first edge after rst deasserts.

Structure
REQ-026 The full-adder cell SHALL be a separate sub-module named full_adder, instantiated WIDTH times via generate.
REQ-027 The shared package SHALL hold the default width constant (ADDER_WIDTH = 4); no typedefs are required.
REQ-028 The implementation SHALL NOT use the behavioural "+" operator for the datapath; the cell chain is the implementation.

Verification
REQ-029 Test: A=5, B=0, Ci=1 -> S=6, Co=0, V=0.
REQ-030 Test: A=5, B=15, Ci=1 -> S=5, Co=1, V=0.
REQ-031 Test: A=15, B=0, Ci=1 -> S=0, Co=1; A=15, B=15, Ci=1 -> S=15, Co=1.
REQ-032 Test: A=7, B=1, Ci=0 -> S=8, Co=0, V=1; A=8, B=8, Ci=0 -> S=0, Co=1, V=1.
REQ-033 Test: A=5, sweep B=0..15 with Ci toggling every 10 ns clock edge -> every {Co,S} equals A+B+Ci, and S_q/Co_q match one cycle later.
REQ-034 Test: rst=1 for one edge while A=9, B=9, Ci=1 -> S_q=0, Co_q=0, V_q=0 that cycle, while S=3, Co=1 hold combinationally; after rst=0 -> S_q=3, Co_q=1.
